aes_encryption_core: RTL and testbench
======================================

# aes_encryption_core

Iterative AES-128 encryption engine: accepts one 128-bit plaintext block and a 128-bit cipher key, performs the initial AddRoundKey plus 10 rounds (one round per clock) with on-the-fly key expansion, and returns the ciphertext. It is the encrypt-side counterpart to the decryption round datapath. It sits between the host-side packet buffer and the output FIFO. Bit 128 of the data word is a side-band tag carried unchanged from input to output.

## Interface
Parameters: none (AES-128 only; Nr = 10 fixed).

- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  asynchronous, active-low reset
- start  input  1  request: key and data_in are sampled on the edge where start=1 and the core is idle/done
- key  input  128  cipher key, byte 0 = key[127:120]
- data_in  input  129  [127:0] plaintext (byte 0 = [127:120], column-major per FIPS-197), [128] tag
- busy  output  1  high while rounds are in progress
- done  output  1  one-cycle pulse, data_out valid
- data_out  output  129  [127:0] ciphertext, [128] tag of the accepted block; held until next accept

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 -> accept: state_reg <= data_in[127:0] ^ key; rkey_reg <= key; tag_reg <= data_in[128]; rnd <= 1; -> RUN.
- RUN, each cycle: next_key = KeyExpand(rkey_reg, Rcon[rnd]); rkey_reg <= next_key.
  - rnd 1..9: state_reg <= MixColumns(ShiftRows(SubBytes(state_reg))) ^ next_key.
  - rnd 10: state_reg <= ShiftRows(SubBytes(state_reg)) ^ next_key (no MixColumns); -> DONE.
  - rnd increments 1..10; 4-bit counter, never wraps past 10.
- KeyExpand: temp = SubWord(RotWord(w3)) ^ {Rcon,24'h0}; w0'=w0^temp, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2' (w0 = key[127:96]).
- Rcon by rnd: 01,02,04,08,10,20,40,80,1B,36.
- Forward S-box: 16 instances on state, 4 on key word; all GF(2^8) arithmetic uses polynomial 0x11B.
- DONE: done=1 for this single cycle. If start=1 in DONE, a new block is accepted (same action as IDLE) -> RUN; else -> IDLE.
- start while RUN: ignored, no queuing; key/data_in changes during RUN have no effect.
- data_out = {tag_reg, state_reg}; output registers are updated only by round logic; after DONE, value is held through IDLE until the next accept overwrites state_reg at its accept edge.

## Timing
- Reset (n_rst=0, any time, including mid-RUN): immediately state=IDLE, busy=0, done=0, data_out=129'h0, rnd=0, rkey_reg=0. Block in flight is discarded; no done pulse.
- Latency: accept on edge E0; rounds on edges E1..E10; done=1 and ciphertext valid in the cycle after E10 (11 cycles accept-to-done).
- busy=1 from the cycle after E0 through the cycle after E9 (RUN); busy=0 in DONE and IDLE.
- Back-to-back throughput: start held high -> one block per 11 cycles (accept in DONE cycle).
- done and busy are register outputs (decoded from state register, no combinational path from start).
- data_out changes during RUN (intermediate state visible); consumers sample only on done.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, data_in {1'b0, 00112233445566778899aabbccddeeff} -> done exactly 11 cycles after accept, data_out = {0, 69c4e0d86a7b0430d8cdb78070b4c55a}, single-cycle done pulse.
- FIPS-197 B: key 2b7e151628aed2a6abf7158809cf4f3c, data {1'b1, 3243f6a8885a308d313198a2e0370734} -> data_out = {1, 3925841d02dc09fbdc118597196a0b32}; tag preserved.
- Back-to-back: start held high with C.1 then B vectors (inputs changed at done cycle) -> two done pulses 11 cycles apart, correct ciphertexts; start during RUN ignored.
- Input stability: change key/data_in every cycle during RUN -> output still C.1 ciphertext.
- Reset mid-operation: assert n_rst low at round 5 -> busy=0, done=0, data_out=0 asynchronously; no done pulse; next start yields correct C.1 result.
- Round-trip: feed C.1 ciphertext and expanded final round key sequence through the decryption round chain -> recovers original plaintext and tag.

Source files
------------

// File: rtl/aes_encryption_core_if.sv
// Host-facing bundle of the AES-128 encrypt core: block request in, ciphertext and status out.
// master = block producer / result consumer, slave = the core.
interface aes_encryption_core_if;
  logic         start;
  logic [127:0] key;
  logic [128:0] data_in;
  logic         busy;
  logic         done;
  logic [128:0] data_out;

  modport master (output start, key, data_in, input  busy, done, data_out);
  modport slave  (input  start, key, data_in, output busy, done, data_out);
endinterface

// File: rtl/aes_encryption_core.sv
// Iterative AES-128 encryptor: initial AddRoundKey, then one round per clock with on-the-fly key expansion.
// Latency: 11 cycles accept-to-done; back-to-back accept in the done cycle gives one block per 11 cycles.
// Backpressure: none; start is only honoured when idle or done, requests during rounds are dropped.
module aes_encryption_core (
  input  logic                 clk,
  input  logic                 n_rst,
  aes_encryption_core_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] LAST_RND = 4'd10;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef struct packed {
    logic         tag;
    logic [127:0] blk;
  } data_t;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    return {sub_word(s[127:96]), sub_word(s[95:64]), sub_word(s[63:32]), sub_word(s[31:0])};
  endfunction

  // Byte n of the block sits at [127-8n -: 8]; row = n%4, column = n/4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]   fsm_q,   fsm_d;
  logic [3:0]   rnd_q,   rnd_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rkey_q,  rkey_d;
  logic         tag_q,   tag_d;

  data_t        in_w;
  logic         accept;
  logic [31:0]  ke_temp, w0_n, w1_n, w2_n, w3_n;
  logic [127:0] next_key, sr_out, mc_out;

  assign in_w   = bus.data_in;
  assign accept = bus.start && (fsm_q == S_IDLE || fsm_q == S_DONE);

  always_comb begin
    ke_temp  = sub_word({rkey_q[23:0], rkey_q[31:24]}) ^ {rcon(rnd_q), 24'h0};
    w0_n     = rkey_q[127:96] ^ ke_temp;
    w1_n     = rkey_q[95:64]  ^ w0_n;
    w2_n     = rkey_q[63:32]  ^ w1_n;
    w3_n     = rkey_q[31:0]   ^ w2_n;
    next_key = {w0_n, w1_n, w2_n, w3_n};
    sr_out   = shift_rows(sub_bytes(state_q));
    mc_out   = mix_columns(sr_out);
  end

  always_comb begin
    fsm_d   = fsm_q;
    rnd_d   = rnd_q;
    state_d = state_q;
    rkey_d  = rkey_q;
    tag_d   = tag_q;
    case (fsm_q)
      S_RUN: begin
        rkey_d = next_key;
        if (rnd_q == LAST_RND) begin
          state_d = sr_out ^ next_key;
          fsm_d   = S_DONE;
        end else begin
          state_d = mc_out ^ next_key;
          rnd_d   = rnd_q + 4'd1;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
    // A new block may be taken straight out of DONE, overriding the return to IDLE.
    if (accept) begin
      state_d = in_w.blk ^ bus.key;
      rkey_d  = bus.key;
      tag_d   = in_w.tag;
      rnd_d   = 4'd1;
      fsm_d   = S_RUN;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      fsm_q   <= S_IDLE;
      rnd_q   <= '0;
      state_q <= '0;
      rkey_q  <= '0;
      tag_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      rnd_q   <= rnd_d;
      state_q <= state_d;
      rkey_q  <= rkey_d;
      tag_q   <= tag_d;
    end
  end

  assign bus.busy     = (fsm_q == S_RUN);
  assign bus.done     = (fsm_q == S_DONE);
  assign bus.data_out = {tag_q, state_q};

endmodule

// File: tb/tb_aes_encryption_core.sv
// Self-checking bench for aes_encryption_core: FIPS-197 vectors, random blocks against a
// byte-array AES model, back-to-back, input stability, mid-run reset and inverse-cipher round trip.
module tb_aes_encryption_core;

  logic clk   = 1'b0;
  logic n_rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  aes_encryption_core_if bus();

  aes_encryption_core dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K_C1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_B  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic [7:0]  sb  [256];
  logic [7:0]  isb [256];
  logic [31:0] kw  [44];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse (x^254) then the affine map.
  task automatic build_sbox();
    logic [7:0] p, x8, s;
    for (int x = 0; x < 256; x++) begin
      x8 = 8'(x);
      p  = 8'h01;
      for (int k = 0; k < 254; k++) p = gmul(p, x8);
      if (x == 0) p = 8'h00;
      s = p ^ rotl8(p, 1) ^ rotl8(p, 2) ^ rotl8(p, 3) ^ rotl8(p, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = x8;
    end
  endtask

  task automatic expand_key(input logic [127:0] k);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) kw[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = kw[i-1];
      if (i % 4 == 0) begin
        t  = {t[23:0], t[31:24]};
        t  = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      kw[i] = kw[i-4] ^ t;
    end
  endtask

  function automatic logic [7:0] rk_byte(input int rd, input int i);
    logic [31:0] w;
    w = kw[4*rd + i/4];
    return w[31 - 8*(i % 4) -: 8];
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk_byte(0, i);
    for (int rd = 1; rd <= 10; rd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r + 4*c] = sb[s[r + 4*((c + r) % 4)]];
      for (int c = 0; c < 4; c++) begin
        if (rd < 10) begin
          s[4*c]   = gmul(8'h02, t[4*c]) ^ gmul(8'h03, t[4*c+1]) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(8'h02, t[4*c+1]) ^ gmul(8'h03, t[4*c+2]) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(8'h02, t[4*c+2]) ^ gmul(8'h03, t[4*c+3]);
          s[4*c+3] = gmul(8'h03, t[4*c]) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(8'h02, t[4*c+3]);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c + r] = t[4*c + r];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk_byte(rd, i);
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] decrypt(input logic [127:0] ct);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = ct[127 - 8*i -: 8] ^ rk_byte(10, i);
    for (int rd = 9; rd >= 0; rd--) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r + 4*((c + r) % 4)] = isb[s[r + 4*c]];
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ rk_byte(rd, i);
      if (rd > 0) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(8'h0e, a0) ^ gmul(8'h0b, a1) ^ gmul(8'h0d, a2) ^ gmul(8'h09, a3);
          s[4*c+1] = gmul(8'h09, a0) ^ gmul(8'h0e, a1) ^ gmul(8'h0b, a2) ^ gmul(8'h0d, a3);
          s[4*c+2] = gmul(8'h0d, a0) ^ gmul(8'h09, a1) ^ gmul(8'h0e, a2) ^ gmul(8'h0b, a3);
          s[4*c+3] = gmul(8'h0b, a0) ^ gmul(8'h0d, a1) ^ gmul(8'h09, a2) ^ gmul(8'h0e, a3);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Accepts one block and waits (bounded) for done; lat = edges from accept to done, -1 on timeout.
  task automatic run_block(input logic [127:0] k, input logic [128:0] d,
                           output int lat, output logic [128:0] out, output int busy_cnt);
    bus.key     = k;
    bus.data_in = d;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
    lat         = -1;
    busy_cnt    = 0;
    out         = '0;
    for (int n = 0; n <= 30; n++) begin
      if (bus.done) begin
        lat = n;
        out = bus.data_out;
        break;
      end
      if (bus.busy) busy_cnt++;
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", bus.done); end
    total++; if (bus.data_out !== 129'h0) begin bad++; $display("FAIL reset_dout: got %h want 0", bus.data_out); end
    tick();
    tick();
    n_rst = 1'b1;
    tick();
    tick();
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_fips_c1();
    int lat, bc;
    logic [128:0] out;
    run_block(K_C1, {1'b0, P_C1}, lat, out, bc);
    total++; if (lat !== 10) begin bad++; $display("FAIL c1_latency: got %0d edges want 10", lat); end
    total++; if (bc !== 10) begin bad++; $display("FAIL c1_busy_cycles: got %0d want 10", bc); end
    total++; if (out !== {1'b0, C_C1}) begin bad++; $display("FAIL c1_ct: got %h want %h", out, {1'b0, C_C1}); end
    tick();
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL c1_pulse: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    tick();
    total++; if (bus.data_out !== {1'b0, C_C1}) begin bad++; $display("FAIL c1_hold: got %h want %h", bus.data_out, {1'b0, C_C1}); end
  endtask

  task automatic test_fips_b();
    int lat, bc;
    logic [128:0] out;
    run_block(K_B, {1'b1, P_B}, lat, out, bc);
    total++; if (lat !== 10) begin bad++; $display("FAIL b_latency: got %0d edges want 10", lat); end
    total++; if (out !== {1'b1, C_B}) begin bad++; $display("FAIL b_ct: got %h want %h", out, {1'b1, C_B}); end
    tick();
  endtask

  task automatic test_random();
    int lat, bc;
    logic [128:0] out, exp;
    logic [127:0] k, p;
    logic tg;
    for (int it = 0; it < 8; it++) begin
      k  = rand128();
      p  = rand128();
      tg = 1'($urandom_range(0, 1));
      expand_key(k);
      exp = {tg, encrypt(p)};
      run_block(k, {tg, p}, lat, out, bc);
      total++; if (lat !== 10 || out !== exp) begin
        bad++; $display("FAIL rand_%0d: got %h lat=%0d want %h lat=10", it, out, lat, exp);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int first, second;
    logic [128:0] out1, out2;
    first  = -1;
    second = -1;
    out1   = '0;
    out2   = '0;
    bus.key     = K_C1;
    bus.data_in = {1'b0, P_C1};
    bus.start   = 1'b1;
    tick();
    for (int n = 0; n <= 40; n++) begin
      if (bus.done) begin
        if (first < 0) begin
          first       = n;
          out1        = bus.data_out;
          bus.key     = K_B;
          bus.data_in = {1'b1, P_B};
        end else begin
          second = n;
          out2   = bus.data_out;
          break;
        end
      end else if (first < 0) begin
        bus.key     = rand128();
        bus.data_in = {1'($urandom_range(0, 1)), rand128()};
      end
      tick();
    end
    bus.start = 1'b0;
    total++; if (first !== 10) begin bad++; $display("FAIL b2b_first_lat: got %0d want 10", first); end
    total++; if (second - first !== 11) begin bad++; $display("FAIL b2b_spacing: got %0d want 11", second - first); end
    total++; if (out1 !== {1'b0, C_C1}) begin bad++; $display("FAIL b2b_ct1: got %h want %h", out1, {1'b0, C_C1}); end
    total++; if (out2 !== {1'b1, C_B}) begin bad++; $display("FAIL b2b_ct2: got %h want %h", out2, {1'b1, C_B}); end
    tick();
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL b2b_stop: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_input_stability();
    int lat;
    logic [128:0] out;
    lat = -1;
    out = '0;
    bus.key     = K_C1;
    bus.data_in = {1'b0, P_C1};
    bus.start   = 1'b1;
    tick();
    for (int n = 0; n <= 30; n++) begin
      if (bus.done) begin
        bus.start = 1'b0;
        lat       = n;
        out       = bus.data_out;
        break;
      end
      bus.key     = rand128();
      bus.data_in = {1'($urandom_range(0, 1)), rand128()};
      bus.start   = 1'($urandom_range(0, 1));
      tick();
    end
    bus.start = 1'b0;
    total++; if (lat !== 10 || out !== {1'b0, C_C1}) begin
      bad++; $display("FAIL stability: got %h lat=%0d want %h lat=10", out, lat, {1'b0, C_C1});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat, bc, pulses;
    logic [128:0] out;
    bus.key     = K_C1;
    bus.data_in = {1'b1, P_C1};
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int n = 0; n < 5; n++) tick();
    #2;
    n_rst = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      bad++; $display("FAIL midrst_flags: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    total++; if (bus.data_out !== 129'h0) begin bad++; $display("FAIL midrst_dout: got %h want 0", bus.data_out); end
    tick();
    tick();
    n_rst  = 1'b1;
    pulses = 0;
    for (int n = 0; n < 15; n++) begin
      if (bus.done || bus.busy) pulses++;
      tick();
    end
    total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_no_done: got %0d active cycles want 0", pulses); end
    run_block(K_C1, {1'b0, P_C1}, lat, out, bc);
    total++; if (lat !== 10 || out !== {1'b0, C_C1}) begin
      bad++; $display("FAIL midrst_rerun: got %h lat=%0d want %h lat=10", out, lat, {1'b0, C_C1});
    end
    tick();
  endtask

  task automatic test_round_trip();
    int lat, bc;
    logic [128:0] out;
    logic [127:0] k, p;
    run_block(K_C1, {1'b0, P_C1}, lat, out, bc);
    expand_key(K_C1);
    total++; if (decrypt(out[127:0]) !== P_C1 || out[128] !== 1'b0) begin
      bad++; $display("FAIL rt_c1: got pt=%h tag=%b want pt=%h tag=0", decrypt(out[127:0]), out[128], P_C1);
    end
    tick();
    k = rand128();
    p = rand128();
    run_block(k, {1'b1, p}, lat, out, bc);
    expand_key(k);
    total++; if (decrypt(out[127:0]) !== p || out[128] !== 1'b1) begin
      bad++; $display("FAIL rt_rand: got pt=%h tag=%b want pt=%h tag=1", decrypt(out[127:0]), out[128], p);
    end
    tick();
  endtask

  initial begin
    bus.start   = 1'b0;
    bus.key     = '0;
    bus.data_in = '0;
    build_sbox();
    #1 n_rst = 1'b0;
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_random();
    test_back_to_back();
    test_input_stability();
    test_reset_mid();
    test_round_trip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
